arb_mux_n: RTL and testbench
============================

ARB_MUX_N -- requirements
Module: arb_mux_n

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, data width per channel (1..64).
REQ-002 SHALL provide parameter CHANNELS, default 4, input channel count (2..8).
REQ-003 SHALL provide parameter SELW, default 2, select/index width (>= ceil(log2(CHANNELS))).
REQ-004 SHALL take clk  input  1  the single clock; all state changes on rising edge.
REQ-005 SHALL take rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL take mode  input  1  0 = fixed select, 1 = round-robin arbitration.
REQ-007 SHALL take select  input  SELW  channel index used when mode=0.
REQ-008 SHALL take in_valid  input  CHANNELS  per-channel data-valid.
REQ-009 SHALL take in_data  input  CHANNELS*WIDTH  packed data, channel i in bits [i*WIDTH +: WIDTH].
REQ-010 SHALL drive in_ready  output  CHANNELS  per-channel accept strobe.
REQ-011 SHALL drive q_valid  output  1  registered output holds valid data.
REQ-012 SHALL take q_ready  input  1  downstream accepts q this cycle.
REQ-013 SHALL drive q  output  WIDTH  registered selected data.
REQ-014 SHALL drive q_chan  output  SELW  index of channel that supplied q.

Function
REQ-015 SHALL define load = ~q_valid | q_ready; output register accepts new data only when load=1.
REQ-016 SHALL assert in_ready[i] combinationally iff grant[i] & load; at most one in_ready bit high per cycle.
REQ-017 SHALL, mode=0: grant = one-hot(select) when select < CHANNELS, else no grant; in_valid of other channels ignored.
REQ-018 SHALL, mode=1: grant the first channel with in_valid=1 scanning ptr, ptr+1, ... wrapping modulo CHANNELS; no grant if none valid.
REQ-019 SHALL transfer from channel k when in_valid[k] & in_ready[k]: next cycle q = channel k data, q_chan = k, q_valid = 1 (latency one cycle).
REQ-020 SHALL, on transfer in mode=1, set ptr = k+1, wrapping CHANNELS-1 -> 0; ptr unchanged otherwise and in mode=0.
REQ-021 SHALL clear q_valid when q_ready=1 and no transfer occurs that cycle; q and q_chan hold last values.
REQ-022 SHALL hold q, q_chan, q_valid stable while q_valid=1 and q_ready=0 (backpressure), regardless of inputs or mode.
REQ-023 SHALL sustain one transfer per cycle when q_ready held 1 (simultaneous drain and load).
REQ-024 SHALL apply mode/select changes to the next arbitration only; a held output is never altered.

Reset
REQ-025 SHALL, while rst_n=0, force q_valid=0, q=0, q_chan=0, ptr=0, counter=0 immediately, independent of clk.
REQ-026 SHALL drop in_ready to all-zero during reset; data in the output register at reset assertion is discarded.
REQ-027 SHALL resume arbitration on the first rising edge after rst_n deasserts, starting from channel 0.

Configuration
REQ-028 SHALL, with ARB_MUX_STATS_EN defined, add output xfer_count (16 bits): increments on each downstream transfer (q_valid & q_ready), saturates at 0xFFFF, reset to 0.
REQ-029 SHALL, with ARB_MUX_STATS_EN undefined, omit the xfer_count port and its counter; all other behaviour identical.

Verification
REQ-030 SHALL cover fixed mode: mode=0, select=2, all in_valid=1, q_ready=1 -> only in_ready[2]=1, q = channel 2 data one cycle later, q_chan=2.
REQ-031 SHALL cover round-robin fairness: mode=1, CHANNELS=4, all valid, q_ready=1 for 8 cycles -> q_chan sequence 0,1,2,3,0,1,2,3.
REQ-032 SHALL cover sparse/wrap: mode=1, ptr=3, only in_valid[1]=1 -> channel 1 granted, ptr becomes 2; only in_valid[3] next -> granted, ptr wraps to 0.
REQ-033 SHALL cover backpressure: q_valid=1, q_ready=0 for 5 cycles with changing inputs -> q, q_chan constant, in_ready=0; q_ready=1 -> new item loaded same cycle.
REQ-034 SHALL cover reset mid-transfer: rst_n pulled low between clock edges while q_valid=1 -> q_valid=0 and q=0 immediately; first post-reset grant is lowest valid channel >= 0.
REQ-035 SHALL cover stats (ARB_MUX_STATS_EN): 70000 back-to-back transfers -> xfer_count reads 0xFFFF and stays there.

Source files
------------

// File: rtl/arb_mux_n_if.sv
// Handshake bundle for arb_mux_n: per-channel inputs, registered output and
// the optional transfer counter (present only when ARB_MUX_STATS_EN is defined).
interface arb_mux_n_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2
);
  logic                      mode;
  logic [SELW-1:0]           select;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_ready;
  logic                      q_valid;
  logic                      q_ready;
  logic [WIDTH-1:0]          q;
  logic [SELW-1:0]           q_chan;
`ifdef ARB_MUX_STATS_EN
  logic [15:0]               xfer_count;

  modport slave (
    input  mode, select, in_valid, in_data, q_ready,
    output in_ready, q_valid, q, q_chan, xfer_count
  );

  modport master (
    output mode, select, in_valid, in_data, q_ready,
    input  in_ready, q_valid, q, q_chan, xfer_count
  );
`else
  modport slave (
    input  mode, select, in_valid, in_data, q_ready,
    output in_ready, q_valid, q, q_chan
  );

  modport master (
    output mode, select, in_valid, in_data, q_ready,
    input  in_ready, q_valid, q, q_chan
  );
`endif
endinterface

// File: rtl/arb_mux_n.sv
// N-channel mux/arbiter with one registered output stage: fixed select or
// round-robin grant. Define ARB_MUX_STATS_EN to add the saturating xfer_count.
module arb_mux_n #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  arb_mux_n_if.slave bus
);

  logic                r_q_valid;
  logic [WIDTH-1:0]    r_q;
  logic [SELW-1:0]     r_q_chan;
  logic [SELW-1:0]     r_ptr;

  logic                w_load;
  logic                w_grant_valid;
  logic [SELW-1:0]     w_grant_idx;
  logic                w_rr_found;
  logic [SELW-1:0]     w_rr_idx;
  logic [SELW:0]       w_scan;
  logic                w_sel_in_range;
  logic                w_xfer;
  logic [SELW-1:0]     w_next_ptr;
  logic [WIDTH-1:0]    w_sel_data;
  logic [CHANNELS-1:0] w_ready;

  assign w_load         = ~r_q_valid | bus.q_ready;
  assign w_sel_in_range = ({1'b0, bus.select} < (SELW+1)'(CHANNELS));

  // Rotating-priority scan starting at r_ptr; the wrap is done by subtraction
  // so CHANNELS need not be a power of two.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_scan     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_scan = {1'b0, r_ptr} + (SELW+1)'(i);
      if (w_scan >= (SELW+1)'(CHANNELS))
        w_scan = w_scan - (SELW+1)'(CHANNELS);
      if (!w_rr_found && bus.in_valid[w_scan[SELW-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_scan[SELW-1:0];
      end
    end
  end

  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    if (bus.mode) begin
      w_grant_valid = w_rr_found;
      w_grant_idx   = w_rr_idx;
    end else if (w_sel_in_range) begin
      w_grant_valid = 1'b1;
      w_grant_idx   = bus.select;
    end
  end

  // Gating with rst_n keeps in_ready low for the whole reset window, not just after the next edge.
  always_comb begin
    w_ready = '0;
    if (rst_n && w_load && w_grant_valid)
      w_ready[w_grant_idx] = 1'b1;
  end

  assign w_xfer     = rst_n & w_load & w_grant_valid & bus.in_valid[w_grant_idx];
  assign w_sel_data = bus.in_data[w_grant_idx*WIDTH +: WIDTH];
  assign w_next_ptr = (w_grant_idx == SELW'(CHANNELS-1)) ? '0 : w_grant_idx + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_valid <= 1'b0;
      r_q       <= '0;
      r_q_chan  <= '0;
    end else if (w_load) begin
      if (w_xfer) begin
        r_q_valid <= 1'b1;
        r_q       <= w_sel_data;
        r_q_chan  <= w_grant_idx;
      end else begin
        r_q_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ptr <= '0;
    else if (w_xfer && bus.mode)
      r_ptr <= w_next_ptr;
  end

`ifdef ARB_MUX_STATS_EN
  logic [15:0] r_xfer_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_xfer_count <= '0;
    else if (r_q_valid && bus.q_ready && (r_xfer_count != 16'hFFFF))
      r_xfer_count <= r_xfer_count + 16'd1;
  end

  assign bus.xfer_count = r_xfer_count;
`endif

  assign bus.in_ready = w_ready;
  assign bus.q_valid  = r_q_valid;
  assign bus.q        = r_q;
  assign bus.q_chan   = r_q_chan;

endmodule

// File: tb/tb_arb_mux_n.sv
// Self-checking bench for arb_mux_n: directed scenarios plus random traffic
// compared against a behavioural model of the grant/transfer rules.
module tb_arb_mux_n;
  localparam int WIDTH    = 16;
  localparam int CHANNELS = 4;
  localparam int SELW     = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  arb_mux_n_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SELW(SELW)) bus ();

  arb_mux_n #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SELW(SELW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int               m_ptr;
  bit               m_qv;
  logic [WIDTH-1:0] m_q;
  int               m_qc;
  int               m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] chan_data(input int c);
    return bus.in_data[c*WIDTH +: WIDTH];
  endfunction

  task automatic model_grant(output bit gv, output int gi);
    gv = 1'b0;
    gi = 0;
    if (bus.mode == 1'b0) begin
      if (int'(bus.select) < CHANNELS) begin
        gv = 1'b1;
        gi = int'(bus.select);
      end
    end else begin
      for (int off = 0; off < CHANNELS; off++) begin
        int c = (m_ptr + off) % CHANNELS;
        if (!gv && bus.in_valid[c]) begin
          gv = 1'b1;
          gi = c;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_qv  = 1'b0;
    m_q   = '0;
    m_qc  = 0;
    m_cnt = 0;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < CHANNELS; i++)
      bus.in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
  endtask

  // One clock: check in_ready before the edge, advance the model, check outputs after.
  task automatic cycle(input string tag);
    bit                  gv;
    int                  gi;
    bit                  load;
    bit                  xfer;
    logic [CHANNELS-1:0] exp_rdy;
    #1;
    model_grant(gv, gi);
    load    = !m_qv || bus.q_ready;
    exp_rdy = '0;
    if (gv && load) exp_rdy[gi] = 1'b1;
    xfer = gv && load && bus.in_valid[gi];
    check($sformatf("%s.in_ready", tag), 64'(bus.in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (m_qv && bus.q_ready && m_cnt < 65535) m_cnt++;
    if (load) begin
      if (xfer) begin
        m_qv = 1'b1;
        m_q  = chan_data(gi);
        m_qc = gi;
        if (bus.mode) m_ptr = (gi + 1) % CHANNELS;
      end else begin
        m_qv = 1'b0;
      end
    end
    #1;
    check($sformatf("%s.q_valid", tag), 64'(bus.q_valid), 64'(m_qv));
    check($sformatf("%s.q", tag),       64'(bus.q),       64'(m_q));
    check($sformatf("%s.q_chan", tag),  64'(bus.q_chan),  64'(m_qc));
`ifdef ARB_MUX_STATS_EN
    check($sformatf("%s.xfer_count", tag), 64'(bus.xfer_count), 64'(m_cnt));
`endif
  endtask

  logic [WIDTH-1:0] saved_q;
  int               saved_chan;

  initial begin
    bus.mode     = 1'b0;
    bus.select   = '0;
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.q_ready  = 1'b0;
    model_reset();

    // Asynchronous reset, observed before any clock edge
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset.q_valid",  64'(bus.q_valid),  64'd0);
    check("reset.q",        64'(bus.q),        64'd0);
    check("reset.q_chan",   64'(bus.q_chan),   64'd0);
    check("reset.in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Fixed select: only channel 2 is offered in_ready and supplies q
    bus.mode     = 1'b0;
    bus.select   = SELW'(2);
    bus.in_valid = '1;
    bus.q_ready  = 1'b1;
    randomize_data();
    saved_q = chan_data(2);
    cycle("fixed");
    check("fixed.q_chan_is_2", 64'(bus.q_chan), 64'd2);
    check("fixed.q_is_ch2",    64'(bus.q),      64'(saved_q));

    // Round-robin fairness from ptr=0
    bus.mode     = 1'b1;
    bus.in_valid = '1;
    for (int i = 0; i < 8; i++) begin
      randomize_data();
      cycle("rr");
      check($sformatf("rr.seq%0d", i), 64'(bus.q_chan), 64'(i % CHANNELS));
    end

    // Sparse requests and pointer wrap
    bus.in_valid = 4'b0100;
    randomize_data();
    cycle("sparse.c2");
    check("sparse.c2.chan", 64'(bus.q_chan), 64'd2);
    bus.in_valid = 4'b0010;
    randomize_data();
    cycle("sparse.c1");
    check("sparse.c1.chan", 64'(bus.q_chan), 64'd1);
    bus.in_valid = 4'b1000;
    randomize_data();
    cycle("sparse.c3");
    check("sparse.c3.chan", 64'(bus.q_chan), 64'd3);
    bus.in_valid = '1;
    randomize_data();
    cycle("sparse.wrap");
    check("sparse.wrap.chan", 64'(bus.q_chan), 64'd0);

    // Backpressure: output held while inputs and mode churn
    saved_q    = bus.q;
    saved_chan = int'(bus.q_chan);
    bus.q_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.mode     = 1'($urandom);
      bus.select   = SELW'($urandom);
      bus.in_valid = CHANNELS'($urandom);
      randomize_data();
      cycle("bp");
      check($sformatf("bp.hold_q%0d", i),    64'(bus.q),      64'(saved_q));
      check($sformatf("bp.hold_chan%0d", i), 64'(bus.q_chan), 64'(saved_chan));
    end
    bus.mode     = 1'b1;
    bus.in_valid = '1;
    bus.q_ready  = 1'b1;
    randomize_data();
    cycle("bp.release");

    // Drain with nothing offered: q_valid clears, data holds
    bus.in_valid = '0;
    bus.mode     = 1'b1;
    cycle("drain");
    check("drain.q_valid_low", 64'(bus.q_valid), 64'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bus.mode     = 1'($urandom);
      bus.select   = SELW'($urandom);
      bus.in_valid = CHANNELS'($urandom);
      bus.q_ready  = ($urandom_range(3, 0) != 0);
      randomize_data();
      cycle("rand");
    end

    // Reset in the middle of a held transfer
    bus.mode     = 1'b1;
    bus.in_valid = '1;
    bus.q_ready  = 1'b1;
    randomize_data();
    cycle("pre_reset");
    bus.q_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst.q_valid",  64'(bus.q_valid),  64'd0);
    check("midrst.q",        64'(bus.q),        64'd0);
    check("midrst.q_chan",   64'(bus.q_chan),   64'd0);
    check("midrst.in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("midrst.hold_q_valid", 64'(bus.q_valid), 64'd0);
    #2 rst_n = 1'b1;
    bus.in_valid = 4'b0110;
    bus.q_ready  = 1'b1;
    randomize_data();
    cycle("postrst");
    check("postrst.first_chan", 64'(bus.q_chan), 64'd1);

`ifdef ARB_MUX_STATS_EN
    // Saturation of the transfer counter
    bus.mode     = 1'b1;
    bus.in_valid = '1;
    bus.q_ready  = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    check("stats.saturated", 64'(bus.xfer_count), 64'hFFFF);
    repeat (4) @(posedge clk);
    #1;
    check("stats.stays", 64'(bus.xfer_count), 64'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
